mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage directly downstream of the ALU. Takes the ALU result (effective address or
//  plain result) and executes LW/LB/LBU/SW/SB against the data memory over a req/ready handshake.
//  Formats load data and registers {result, dest, reg_write} for writeback.
//  Stalls the upstream stages while a memory access is outstanding.
// PARAMETERS
//  WIDTH  32  datapath/address width; byte-lane logic is defined for WIDTH=32 only
// PORTS
//  clock            in   1      single clock, rising edge
//  reset            in   1      asynchronous, active-high
//  w_valid_in       in   1      EX result valid this cycle
//  w_mem_op         in   1      opcode is in the memory/LUI class (same meaning as at the ALU)
//  w_op_code_6      in   6      opcode (`LW,`LB,`LBU,`SW,`SB,`LUI from isa_codes.v)
//  w_alu_result_x   in   WIDTH  ALU output: address for loads/stores, result otherwise
//  w_store_data_x   in   WIDTH  rt value for stores
//  w_dest_reg_5     in   5      destination register
//  w_reg_write      in   1      instruction writes the register file
//  w_stall_out      out  1      upstream must hold its outputs
//  w_mem_req        out  1      memory request
//  w_mem_we         out  1      1=write
//  w_mem_addr       out  WIDTH  word-aligned address ({addr[31:2],2'b00})
//  w_mem_wdata      out  WIDTH  write data
//  w_mem_be         out  4      byte enables
//  w_mem_ready      in   1      memory completes the request this cycle
//  w_mem_rdata      in   WIDTH  read data, valid when w_mem_ready
//  w_valid_out      out  1      WB fields valid
//  w_result_x       out  WIDTH  writeback value
//  w_dest_reg_out_5 out  5      writeback destination
//  w_reg_write_out  out  1      writeback enable (qualified by w_valid_out)
//  w_exc_misaligned out  1      one-cycle pulse: misaligned LW/SW
// BEHAVIOUR
//  Reset: state IDLE; every output 0; w_result_x 0.
//  access = w_valid_in & w_mem_op & op in {LW,LB,LBU,SW,SB}; LUI and all non-mem ops pass through.
//  FSM IDLE/REQ:
//   IDLE, access & aligned -> capture op/addr/data/dest, go REQ; w_valid_out=0 next cycle.
//   IDLE, pass-through valid -> next cycle valid_out=1, result=alu_result, dest/reg_write copied.
//   IDLE, LW/SW with addr[1:0]!=0 -> no request; next cycle exc pulse=1, valid_out=0; stay IDLE.
//   REQ: req=1 with addr/we/wdata/be stable until w_mem_ready. On the ready cycle go IDLE;
//    next cycle valid_out=1 (loads: formatted rdata, reg_write=captured; stores: reg_write=0).
//  w_mem_ready outside REQ is ignored. Zero-wait memory (ready in the first REQ cycle) gives a
//   2-cycle load latency: accept at t, req at t+1, valid_out at t+2.
//  w_stall_out = (state==REQ). Inputs presented while stalled are not sampled. Upstream holds them.
//  w_valid_out and w_exc_misaligned are single-cycle pulses; there is no backpressure from WB.
//  Byte lanes are little-endian, lane = addr[1:0]:
//   LW: be=4'hF; LB: sign-extend rdata byte[lane]; LBU: zero-extend.
//   SW: be=4'hF, wdata=store_data; SB: be=4'b0001<<lane, wdata={4{store_data[7:0]}}.
//   LB/LBU/SB never raise misaligned.
//  Loads writing r0 proceed normally; WB discards them.
//  Reset asserted mid-REQ drops req immediately (async) and discards the access. Memory tolerates it.
// STRUCTURE
//  Opcodes come from shared isa_codes.v. FSM state encodings are localparams in this file.
//  Sub-module load_formatter (comb): {op, lane, rdata} -> WIDTH result (byte select + extend).
// TESTING
//  1 ADDU pass-through, alu_result=0x1234 dest=5 -> next cycle valid_out=1 result=0x1234 dest=5.
//  2 LW addr 0x100, ready after 3 REQ cycles, rdata=0xDEADBEEF -> addr/be stable, stall=1 for 3 cycles,
//    then valid_out=1 result=0xDEADBEEF.
//  3 LB addr 0x103, rdata=0x80FF_0000 -> result=0xFFFFFF80. LBU at the same address -> 0x00000080.
//  4 SB addr 0x202, store_data=0x000000AB -> we=1, be=4'b0100, wdata=0xABABABAB; reg_write_out=0.
//  5 SW addr 0x101 -> no req, exc pulse=1, valid_out=0; a following ADDU completes normally.
//  6 Reset in 2nd REQ cycle of LW -> req=0 same cycle, valid_out stays 0, next LW executes cleanly.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the MEM pipeline stage: the opcodes of the memory/LUI
// class, the record captured when a load or store is accepted, and small
// helpers that decode opcodes and build store byte lanes.
// Byte-lane helpers assume a 32-bit datapath (four little-endian lanes).
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

    localparam int DATA_W = 32;

    // Memory-class opcodes (same values as the shared ISA opcode table)
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_LUI = 6'h0F;

    // Everything the stage needs to drive and finish one memory access
    typedef struct packed {
        logic [5:0]        op;
        logic [DATA_W-1:0] addr;
        logic [1:0]        lane;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        be;
        logic              we;
        logic [4:0]        dest;
        logic              regWrite;
    } memAccess_t;

    // True for the opcodes that actually touch data memory (LUI excluded)
    function automatic logic isAccessOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic isStoreOp(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    // Only full-word accesses have an alignment requirement
    function automatic logic isWordOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Loads always read the whole word; the formatter picks the byte later
    function automatic logic [3:0] storeByteEnable(input logic [5:0] op,
                                                   input logic [1:0] lane);
        if (op == OP_SB) begin
            return 4'b0001 << lane;
        end
        return 4'hF;
    endfunction

    // SB replicates the byte on every lane so the enable alone selects it
    function automatic logic [DATA_W-1:0] storeData(input logic [5:0]        op,
                                                    input logic [DATA_W-1:0] data);
        case (op)
            OP_SW:   return data;
            OP_SB:   return {4{data[7:0]}};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// -----------------------------------------------------------------------------
// load_formatter
// Combinational load-data formatting: selects the addressed byte for LB/LBU
// and sign- or zero-extends it; LW passes the word through unchanged.
// Ports:
//   op_i      load opcode captured with the access
//   lane_i    byte lane (address bits [1:0]), little-endian
//   rdata_i   raw word returned by data memory
//   result_o  value to write back
// -----------------------------------------------------------------------------
module load_formatter
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [5:0]       op_i,
    input  logic [1:0]       lane_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic [WIDTH-1:0] result_o
);

    logic [7:0] selByte;

    // Pick the addressed byte, then extend it according to the load flavour
    always_comb begin
        case (lane_i)
            2'd0:    selByte = rdata_i[7:0];
            2'd1:    selByte = rdata_i[15:8];
            2'd2:    selByte = rdata_i[23:16];
            default: selByte = rdata_i[31:24];
        endcase

        case (op_i)
            OP_LB:   result_o = {{(WIDTH-8){selByte[7]}}, selByte};
            OP_LBU:  result_o = {{(WIDTH-8){1'b0}}, selByte};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage after the ALU. Executes LW/LB/LBU/SW/SB against data
// memory over a req/ready handshake, formats load data, and registers the
// writeback fields. Non-memory ops and LUI pass straight through in one cycle.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   w_valid_in ..       EX-stage result, opcode, store data, destination
//   w_stall_out         high while an access is outstanding (upstream holds)
//   w_mem_*             data-memory request side; ready/rdata come back
//   w_valid_out ..      one-cycle writeback pulse with result/dest/enable
//   w_exc_misaligned    one-cycle pulse for an unaligned LW/SW
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             w_valid_in,
    input  logic             w_mem_op,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_alu_result_x,
    input  logic [WIDTH-1:0] w_store_data_x,
    input  logic [4:0]       w_dest_reg_5,
    input  logic             w_reg_write,
    output logic             w_stall_out,
    output logic             w_mem_req,
    output logic             w_mem_we,
    output logic [WIDTH-1:0] w_mem_addr,
    output logic [WIDTH-1:0] w_mem_wdata,
    output logic [3:0]       w_mem_be,
    input  logic             w_mem_ready,
    input  logic [WIDTH-1:0] w_mem_rdata,
    output logic             w_valid_out,
    output logic [WIDTH-1:0] w_result_x,
    output logic [4:0]       w_dest_reg_out_5,
    output logic             w_reg_write_out,
    output logic             w_exc_misaligned
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]       state_q, state_d;
    memAccess_t       pending_q, pending_d;
    logic             validOut_q, validOut_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       destOut_q, destOut_d;
    logic             regWriteOut_q, regWriteOut_d;
    logic             excMisaligned_q, excMisaligned_d;

    logic             isAccess;
    logic             isMisaligned;
    logic             inRequest;
    logic [WIDTH-1:0] loadResult;

    load_formatter #(.WIDTH(WIDTH)) u_load_formatter (
        .op_i     (pending_q.op),
        .lane_i   (pending_q.lane),
        .rdata_i  (w_mem_rdata),
        .result_o (loadResult)
    );

    // Next-state logic: accept, reject or pass through in IDLE; wait for ready in REQ.
    // Writeback pulses default low so they only last one cycle.
    always_comb begin
        isAccess        = w_valid_in & w_mem_op & isAccessOp(w_op_code_6);
        isMisaligned    = isWordOp(w_op_code_6) & (w_alu_result_x[1:0] != 2'b00);

        state_d         = state_q;
        pending_d       = pending_q;
        validOut_d      = 1'b0;
        result_d        = result_q;
        destOut_d       = destOut_q;
        regWriteOut_d   = 1'b0;
        excMisaligned_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (isAccess) begin
                    if (isMisaligned) begin
                        excMisaligned_d = 1'b1;
                    end else begin
                        pending_d.op       = w_op_code_6;
                        pending_d.addr     = {w_alu_result_x[WIDTH-1:2], 2'b00};
                        pending_d.lane     = w_alu_result_x[1:0];
                        pending_d.wdata    = storeData(w_op_code_6, w_store_data_x);
                        pending_d.be       = storeByteEnable(w_op_code_6, w_alu_result_x[1:0]);
                        pending_d.we       = isStoreOp(w_op_code_6);
                        pending_d.dest     = w_dest_reg_5;
                        pending_d.regWrite = w_reg_write;
                        state_d            = ST_REQ;
                    end
                end else if (w_valid_in) begin
                    validOut_d    = 1'b1;
                    result_d      = w_alu_result_x;
                    destOut_d     = w_dest_reg_5;
                    regWriteOut_d = w_reg_write;
                end
            end
            ST_REQ: begin
                if (w_mem_ready) begin
                    state_d    = ST_IDLE;
                    validOut_d = 1'b1;
                    destOut_d  = pending_q.dest;
                    // Stores complete with no register write; the old result is left alone
                    if (!pending_q.we) begin
                        result_d      = loadResult;
                        regWriteOut_d = pending_q.regWrite;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any outstanding access
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            pending_q       <= '0;
            validOut_q      <= 1'b0;
            result_q        <= '0;
            destOut_q       <= '0;
            regWriteOut_q   <= 1'b0;
            excMisaligned_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            validOut_q      <= validOut_d;
            result_q        <= result_d;
            destOut_q       <= destOut_d;
            regWriteOut_q   <= regWriteOut_d;
            excMisaligned_q <= excMisaligned_d;
        end
    end

    // Memory-side outputs are gated by REQ so they read zero whenever idle
    assign inRequest        = (state_q == ST_REQ);
    assign w_stall_out      = inRequest;
    assign w_mem_req        = inRequest;
    assign w_mem_we         = inRequest & pending_q.we;
    assign w_mem_addr       = inRequest ? pending_q.addr  : '0;
    assign w_mem_wdata      = inRequest ? pending_q.wdata : '0;
    assign w_mem_be         = inRequest ? pending_q.be    : 4'h0;

    assign w_valid_out      = validOut_q;
    assign w_result_x       = result_q;
    assign w_dest_reg_out_5 = destOut_q;
    assign w_reg_write_out  = regWriteOut_q;
    assign w_exc_misaligned = excMisaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench for mem_access_stage: a table of directed vectors with
// hand-computed expectations, a reset-during-access sequence, and randomized
// operations whose expectations come from a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clock;
    logic        reset;
    logic        w_valid_in;
    logic        w_mem_op;
    logic [5:0]  w_op_code_6;
    logic [31:0] w_alu_result_x;
    logic [31:0] w_store_data_x;
    logic [4:0]  w_dest_reg_5;
    logic        w_reg_write;
    logic        w_stall_out;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [3:0]  w_mem_be;
    logic        w_mem_ready;
    logic [31:0] w_mem_rdata;
    logic        w_valid_out;
    logic [31:0] w_result_x;
    logic [4:0]  w_dest_reg_out_5;
    logic        w_reg_write_out;
    logic        w_exc_misaligned;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .w_valid_in       (w_valid_in),
        .w_mem_op         (w_mem_op),
        .w_op_code_6      (w_op_code_6),
        .w_alu_result_x   (w_alu_result_x),
        .w_store_data_x   (w_store_data_x),
        .w_dest_reg_5     (w_dest_reg_5),
        .w_reg_write      (w_reg_write),
        .w_stall_out      (w_stall_out),
        .w_mem_req        (w_mem_req),
        .w_mem_we         (w_mem_we),
        .w_mem_addr       (w_mem_addr),
        .w_mem_wdata      (w_mem_wdata),
        .w_mem_be         (w_mem_be),
        .w_mem_ready      (w_mem_ready),
        .w_mem_rdata      (w_mem_rdata),
        .w_valid_out      (w_valid_out),
        .w_result_x       (w_result_x),
        .w_dest_reg_out_5 (w_dest_reg_out_5),
        .w_reg_write_out  (w_reg_write_out),
        .w_exc_misaligned (w_exc_misaligned)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        memOp;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  dest;
        logic        regWr;
        int          waits;
        logic        expReq;
        logic        expWe;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
        logic        expExc;
        logic        expValid;
        logic        expRegWr;
        logic        chkResult;
        logic [31:0] expResult;
    } vec_t;

    // One comparison; every failure prints a single FAIL line
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Builds a vector from inputs plus hand-written expectations
    function automatic vec_t mk(input string name, input logic memOp, input logic [5:0] op,
                                input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic [4:0] dest,
                                input logic regWr, input int waits,
                                input logic expReq, input logic expWe,
                                input logic [31:0] expAddr, input logic [31:0] expWdata,
                                input logic [3:0] expBe, input logic expExc,
                                input logic expValid, input logic expRegWr,
                                input logic chkResult, input logic [31:0] expResult);
        vec_t v;
        v.name = name; v.memOp = memOp; v.op = op; v.alu = alu; v.sdata = sdata;
        v.rdata = rdata; v.dest = dest; v.regWr = regWr; v.waits = waits;
        v.expReq = expReq; v.expWe = expWe; v.expAddr = expAddr; v.expWdata = expWdata;
        v.expBe = expBe; v.expExc = expExc; v.expValid = expValid; v.expRegWr = expRegWr;
        v.chkResult = chkResult; v.expResult = expResult;
        return v;
    endfunction

    // Behavioural reference: what the stage should do for one instruction,
    // worked out from the ISA rules with plain arithmetic
    function automatic vec_t modelExpect(input vec_t v);
        vec_t   r;
        bit     access;
        bit     isStore;
        bit     isWord;
        int     lane;
        int     byteVal;
        r = v;
        access  = v.memOp && (v.op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB});
        isStore = (v.op == OP_SW) || (v.op == OP_SB);
        isWord  = (v.op == OP_LW) || (v.op == OP_SW);
        lane    = int'(v.alu % 4);
        r.expReq = 0; r.expWe = 0; r.expAddr = 0; r.expWdata = 0; r.expBe = 0;
        r.expExc = 0; r.expValid = 0; r.expRegWr = 0; r.chkResult = 0; r.expResult = 0;
        if (!access) begin
            r.expValid  = 1;
            r.expRegWr  = v.regWr;
            r.chkResult = 1;
            r.expResult = v.alu;
        end else if (isWord && lane != 0) begin
            r.expExc = 1;
        end else begin
            r.expReq   = 1;
            r.expWe    = isStore;
            r.expAddr  = v.alu - 32'(lane);
            r.expBe    = (v.op == OP_SB) ? 4'(1 << lane) : 4'hF;
            if (v.op == OP_SW)      r.expWdata = v.sdata;
            else if (v.op == OP_SB) r.expWdata = (v.sdata % 256) * 32'h0101_0101;
            r.expValid  = 1;
            r.expRegWr  = isStore ? 1'b0 : v.regWr;
            r.chkResult = !isStore;
            byteVal = int'((v.rdata >> (8 * lane)) % 256);
            if (v.op == OP_LW)                      r.expResult = v.rdata;
            else if (v.op == OP_LB && byteVal >= 128) r.expResult = 32'(byteVal - 256);
            else                                    r.expResult = 32'(byteVal);
        end
        return r;
    endfunction

    // Memory request side must be stable for every REQ cycle
    task automatic checkReqPhase(input vec_t v, input string tag);
        checkOutput({v.name, " req", tag},   32'(w_mem_req),   32'h1);
        checkOutput({v.name, " stall", tag}, 32'(w_stall_out), 32'h1);
        checkOutput({v.name, " we", tag},    32'(w_mem_we),    32'(v.expWe));
        checkOutput({v.name, " addr", tag},  w_mem_addr,       v.expAddr);
        checkOutput({v.name, " be", tag},    32'(w_mem_be),    32'(v.expBe));
        checkOutput({v.name, " wdata", tag}, w_mem_wdata,      v.expWdata);
        checkOutput({v.name, " vout", tag},  32'(w_valid_out), 32'h0);
    endtask

    // Drives one instruction, answers its memory request after v.waits idle
    // cycles, then checks the writeback / exception pulse and its end
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        w_valid_in     = 1'b1;
        w_mem_op       = v.memOp;
        w_op_code_6    = v.op;
        w_alu_result_x = v.alu;
        w_store_data_x = v.sdata;
        w_dest_reg_5   = v.dest;
        w_reg_write    = v.regWr;
        w_mem_ready    = 1'($urandom_range(0, 1));
        w_mem_rdata    = $urandom;
        @(posedge clock);
        #1;
        w_valid_in  = 1'b0;
        w_mem_ready = 1'b0;
        @(negedge clock);
        if (v.expReq) begin
            checkReqPhase(v, "");
            for (int i = 0; i < v.waits; i++) begin
                @(posedge clock);
                @(negedge clock);
                checkReqPhase(v, " held");
            end
            w_mem_ready = 1'b1;
            w_mem_rdata = v.rdata;
            @(posedge clock);
            #1;
            w_mem_ready = 1'b0;
            w_mem_rdata = $urandom;
            @(negedge clock);
        end
        checkOutput({v.name, " done stall"}, 32'(w_stall_out),      32'h0);
        checkOutput({v.name, " done req"},   32'(w_mem_req),        32'h0);
        checkOutput({v.name, " exc"},        32'(w_exc_misaligned), 32'(v.expExc));
        checkOutput({v.name, " vout"},       32'(w_valid_out),      32'(v.expValid));
        if (v.expValid) begin
            checkOutput({v.name, " regwr"}, 32'(w_reg_write_out),  32'(v.expRegWr));
            checkOutput({v.name, " dest"},  32'(w_dest_reg_out_5), 32'(v.dest));
            if (v.chkResult) checkOutput({v.name, " result"}, w_result_x, v.expResult);
        end
        @(posedge clock);
        @(negedge clock);
        checkOutput({v.name, " vout pulse"}, 32'(w_valid_out),      32'h0);
        checkOutput({v.name, " exc pulse"},  32'(w_exc_misaligned), 32'h0);
    endtask

    vec_t table_q[$];

    initial begin
        vec_t v;
        logic [5:0] opPool [8];

        opPool = '{OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB, OP_LUI, 6'h09, 6'h00};

        //                name        mem op      alu           sdata         rdata        dst rw wt  req we addr          wdata         be    exc val rw chk result
        table_q.push_back(mk("addu",    0, 6'h00,  32'h0000_1234, 32'h0,        32'h0,        5, 1, 0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 1, 1, 32'h0000_1234));
        table_q.push_back(mk("lw100",   1, OP_LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 8, 1, 2, 1, 0, 32'h0000_0100, 32'h0,        4'hF, 0, 1, 1, 1, 32'hDEAD_BEEF));
        table_q.push_back(mk("lb103",   1, OP_LB,  32'h0000_0103, 32'h0,        32'h80FF_0000, 9, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'hF, 0, 1, 1, 1, 32'hFFFF_FF80));
        table_q.push_back(mk("lbu103",  1, OP_LBU, 32'h0000_0103, 32'h0,        32'h80FF_0000, 9, 1, 1, 1, 0, 32'h0000_0100, 32'h0,        4'hF, 0, 1, 1, 1, 32'h0000_0080));
        table_q.push_back(mk("lb100",   1, OP_LB,  32'h0000_0100, 32'h0,        32'h0000_007F, 7, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'hF, 0, 1, 1, 1, 32'h0000_007F));
        table_q.push_back(mk("sb202",   1, OP_SB,  32'h0000_0202, 32'h0000_00AB, 32'h0,        2, 1, 1, 1, 1, 32'h0000_0200, 32'hABAB_ABAB, 4'h4, 0, 1, 0, 0, 32'h0));
        table_q.push_back(mk("sw101",   1, OP_SW,  32'h0000_0101, 32'h1111_2222, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 0, 32'h0));
        table_q.push_back(mk("addu2",   0, 6'h00,  32'h0000_CAFE, 32'h0,        32'h0,        3, 1, 0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 1, 1, 32'h0000_CAFE));
        table_q.push_back(mk("sw204",   1, OP_SW,  32'h0000_0204, 32'h1122_3344, 32'h0,        6, 0, 0, 1, 1, 32'h0000_0204, 32'h1122_3344, 4'hF, 0, 1, 0, 0, 32'h0));
        table_q.push_back(mk("lui",     1, OP_LUI, 32'h1234_0000, 32'h0,        32'h0,        4, 1, 0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 1, 1, 32'h1234_0000));
        table_q.push_back(mk("lw_r0",   1, OP_LW,  32'h0000_0010, 32'h0,        32'h5555_AAAA, 0, 1, 3, 1, 0, 32'h0000_0010, 32'h0,        4'hF, 0, 1, 1, 1, 32'h5555_AAAA));
        table_q.push_back(mk("lb_mis",  1, OP_LB,  32'h0000_0041, 32'h0,        32'h0000_9900, 1, 1, 0, 1, 0, 32'h0000_0040, 32'h0,        4'hF, 0, 1, 1, 1, 32'hFFFF_FF99));

        $display("[TB] reset state");
        reset = 1'b1;
        w_valid_in = 0; w_mem_op = 0; w_op_code_6 = 0; w_alu_result_x = 0;
        w_store_data_x = 0; w_dest_reg_5 = 0; w_reg_write = 0;
        w_mem_ready = 0; w_mem_rdata = 0;
        #1;
        checkOutput("reset stall",  32'(w_stall_out),      32'h0);
        checkOutput("reset req",    32'(w_mem_req),        32'h0);
        checkOutput("reset we",     32'(w_mem_we),         32'h0);
        checkOutput("reset addr",   w_mem_addr,            32'h0);
        checkOutput("reset be",     32'(w_mem_be),         32'h0);
        checkOutput("reset vout",   32'(w_valid_out),      32'h0);
        checkOutput("reset result", w_result_x,            32'h0);
        checkOutput("reset regwr",  32'(w_reg_write_out),  32'h0);
        checkOutput("reset exc",    32'(w_exc_misaligned), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed table");
        foreach (table_q[i]) applyStimulus(table_q[i]);

        $display("[TB] reset during access");
        @(negedge clock);
        w_valid_in = 1; w_mem_op = 1; w_op_code_6 = OP_LW;
        w_alu_result_x = 32'h0000_0300; w_dest_reg_5 = 5'd10; w_reg_write = 1;
        @(posedge clock);
        #1;
        w_valid_in = 0;
        @(negedge clock);
        checkOutput("rst-mid req 1st cycle", 32'(w_mem_req), 32'h1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst-mid req dropped",   32'(w_mem_req),   32'h0);
        checkOutput("rst-mid stall dropped", 32'(w_stall_out), 32'h0);
        checkOutput("rst-mid addr cleared",  w_mem_addr,       32'h0);
        checkOutput("rst-mid vout",          32'(w_valid_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        w_mem_ready = 1'b1;
        w_mem_rdata = 32'hBAD0_BAD0;
        @(posedge clock);
        #1;
        w_mem_ready = 1'b0;
        @(negedge clock);
        checkOutput("rst-mid no writeback", 32'(w_valid_out), 32'h0);
        checkOutput("rst-mid still idle",   32'(w_mem_req),   32'h0);
        applyStimulus(table_q[1]);

        $display("[TB] randomized operations");
        for (int n = 0; n < 60; n++) begin
            v.name  = $sformatf("rand%0d", n);
            v.op    = opPool[$urandom_range(0, 7)];
            if (v.op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB})
                v.memOp = ($urandom_range(0, 7) != 0);
            else
                v.memOp = (v.op == OP_LUI);
            v.alu   = $urandom;
            if ((v.op == OP_LW || v.op == OP_SW) && $urandom_range(0, 2) != 0)
                v.alu = v.alu & 32'hFFFF_FFFC;
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.dest  = 5'($urandom_range(0, 31));
            v.regWr = 1'($urandom_range(0, 1));
            v.waits = $urandom_range(0, 3);
            applyStimulus(modelExpect(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
